// File: rtl/vga_scanout_controller_pkg.sv
// Shared timing defaults, RGB332 field layout and colour helpers for the VGA scanout path.
// The VGA_TEST_PATTERN_EN macro adds the colour-bar index to the alignment pipeline.
package vga_scanout_controller_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_FB_LATENCY = 1;
  localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // RGB332 field positions
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Per-pixel control bits that travel alongside the framebuffer read
  typedef struct packed {
    logic       active;
    logic       hs_on;
    logic       vs_on;
    logic       sel;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } pipe_t;

  function automatic logic [23:0] expand_rgb332(input logic [7:0] p);
    logic [2:0] r_s;
    logic [2:0] g_s;
    logic [1:0] b_s;
    r_s = p[R_MSB:R_LSB];
    g_s = p[G_MSB:G_LSB];
    b_s = p[B_MSB:B_LSB];
    return {r_s, r_s, r_s[2:1], g_s, g_s, g_s[2:1], b_s, b_s, b_s, b_s};
  endfunction

  function automatic logic [7:0] test_bar_colour(input logic [2:0] idx);
    logic [7:0] c_s;
    case (idx)
      3'd0:    c_s = 8'hFF;
      3'd1:    c_s = 8'hFC;
      3'd2:    c_s = 8'h1F;
      3'd3:    c_s = 8'h1C;
      3'd4:    c_s = 8'hE3;
      3'd5:    c_s = 8'hE0;
      3'd6:    c_s = 8'h03;
      3'd7:    c_s = 8'h00;
      default: c_s = 8'h00;
    endcase
    return c_s;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters with raw active, sync (active-low) and frame-end strobes.
module vga_sync_counter
  import vga_scanout_controller_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic       clock_video,
  input  logic       reset,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h_count_r;
  logic [9:0] v_count_r;
  logic       h_wrap_s;

  assign h_wrap_s = (h_count_r == H_LAST);

  // Scan position counters
  always_ff @(posedge clock_video or negedge reset) begin
    if (!reset) begin
      h_count_r <= 10'd0;
      v_count_r <= 10'd0;
    end else if (h_wrap_s) begin
      h_count_r <= 10'd0;
      if (v_count_r == V_LAST) begin
        v_count_r <= 10'd0;
      end else begin
        v_count_r <= v_count_r + 10'd1;
      end
    end else begin
      h_count_r <= h_count_r + 10'd1;
    end
  end

  // Raw timing decode from the current scan position
  always_comb begin
    active    = 1'b0;
    hs_raw    = 1'b1;
    vs_raw    = 1'b1;
    frame_end = 1'b0;
    if ((h_count_r < H_ACT) && (v_count_r < V_ACT)) active = 1'b1;
    else                                              active = 1'b0;
    if ((h_count_r >= HS_BEG) && (h_count_r < HS_END)) hs_raw = 1'b0;
    else                                                hs_raw = 1'b1;
    if ((v_count_r >= VS_BEG) && (v_count_r < VS_END)) vs_raw = 1'b0;
    else                                                vs_raw = 1'b1;
    if (h_wrap_s && (v_count_r == V_LAST)) frame_end = 1'b1;
    else                                    frame_end = 1'b0;
  end

  assign h_count = h_count_r;
  assign v_count = v_count_r;

endmodule

// File: rtl/vga_scanout_controller.sv
// VGA timing and pixel output stage: issues scan coordinates, aligns returning framebuffer
// pixels with sync, expands RGB332 to 24-bit. Optional colour bars under VGA_TEST_PATTERN_EN.
module vga_scanout_controller
  import vga_scanout_controller_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int FB_LATENCY = DEF_FB_LATENCY
) (
  input  logic       clock_video,
  input  logic       reset,
  input  logic [7:0] pixel_frame0,
  input  logic [7:0] pixel_frame1,
  input  logic       frame_select,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  output logic [9:0] pixel_x_pos,
  output logic [9:0] pixel_y_pos,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vblank
);

  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

  logic [9:0] h_count_s;
  logic [9:0] v_count_s;
  logic       active_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic       frame_end_s;

  logic       displayed_select_r;
  pipe_t      st1_next_s;
  pipe_t      st1_r;
  pipe_t      dly_r [FB_LATENCY];
  pipe_t      pipe_out_s;
  logic [7:0] pix_s;
  logic [23:0] colour_s;

  logic [9:0] pixel_x_pos_r;
  logic [9:0] pixel_y_pos_r;
  logic       vblank_r;
  logic [7:0] vga_r_r;
  logic [7:0] vga_g_r;
  logic [7:0] vga_b_r;
  logic       vga_hsync_r;
  logic       vga_vsync_r;
  logic       vga_blank_n_r;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_sync_counter (
    .clock_video (clock_video),
    .reset       (reset),
    .h_count     (h_count_s),
    .v_count     (v_count_s),
    .active      (active_s),
    .hs_raw      (hs_raw_s),
    .vs_raw      (vs_raw_s),
    .frame_end   (frame_end_s)
  );

  // Buffer choice only changes across a frame boundary so a frame never mixes buffers
  always_ff @(posedge clock_video or negedge reset) begin
    if (!reset) begin
      displayed_select_r <= 1'b0;
    end else if (frame_end_s) begin
      displayed_select_r <= frame_select;
    end else begin
      displayed_select_r <= displayed_select_r;
    end
  end

  // Control bits for the coordinate being issued; sync stored active-high so reset means idle
  always_comb begin
    st1_next_s        = '0;
    st1_next_s.active = active_s;
    st1_next_s.hs_on  = ~hs_raw_s;
    st1_next_s.vs_on  = ~vs_raw_s;
    st1_next_s.sel    = displayed_select_r;
`ifdef VGA_TEST_PATTERN_EN
    st1_next_s.bar    = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_count_s >= 10'((i * H_ACTIVE) / 8)) st1_next_s.bar = 3'(i);
      else                                         st1_next_s.bar = st1_next_s.bar;
    end
`endif
  end

  // Coordinate issue stage; blanking reads park on address 0
  always_ff @(posedge clock_video or negedge reset) begin
    if (!reset) begin
      pixel_x_pos_r <= 10'd0;
      pixel_y_pos_r <= 10'd0;
      vblank_r      <= 1'b0;
      st1_r         <= '0;
    end else begin
      pixel_x_pos_r <= active_s ? h_count_s : 10'd0;
      pixel_y_pos_r <= active_s ? v_count_s : 10'd0;
      vblank_r      <= (v_count_s >= V_ACT);
      st1_r         <= st1_next_s;
    end
  end

  // Delay line matching the framebuffer read latency
  always_ff @(posedge clock_video or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FB_LATENCY; i++) dly_r[i] <= '0;
    end else begin
      dly_r[0] <= st1_r;
      for (int i = 1; i < FB_LATENCY; i++) dly_r[i] <= dly_r[i-1];
    end
  end

  assign pipe_out_s = dly_r[FB_LATENCY-1];

  // Pixel source selection and colour expansion
  always_comb begin
    pix_s    = 8'h00;
    colour_s = 24'h000000;
`ifdef VGA_TEST_PATTERN_EN
    if (test_pattern)        pix_s = test_bar_colour(pipe_out_s.bar);
    else if (pipe_out_s.sel) pix_s = pixel_frame1;
    else                     pix_s = pixel_frame0;
`else
    if (pipe_out_s.sel) pix_s = pixel_frame1;
    else                pix_s = pixel_frame0;
`endif
    if (pipe_out_s.active) colour_s = expand_rgb332(pix_s);
    else                   colour_s = 24'h000000;
  end

  // Output register: colour and sync leave together
  always_ff @(posedge clock_video or negedge reset) begin
    if (!reset) begin
      vga_r_r       <= 8'h00;
      vga_g_r       <= 8'h00;
      vga_b_r       <= 8'h00;
      vga_hsync_r   <= 1'b1;
      vga_vsync_r   <= 1'b1;
      vga_blank_n_r <= 1'b0;
    end else begin
      vga_r_r       <= colour_s[23:16];
      vga_g_r       <= colour_s[15:8];
      vga_b_r       <= colour_s[7:0];
      vga_hsync_r   <= ~pipe_out_s.hs_on;
      vga_vsync_r   <= ~pipe_out_s.vs_on;
      vga_blank_n_r <= pipe_out_s.active;
    end
  end

  assign pixel_x_pos = pixel_x_pos_r;
  assign pixel_y_pos = pixel_y_pos_r;
  assign vblank      = vblank_r;
  assign vga_r       = vga_r_r;
  assign vga_g       = vga_g_r;
  assign vga_b       = vga_b_r;
  assign vga_hsync   = vga_hsync_r;
  assign vga_vsync   = vga_vsync_r;
  assign vga_blank_n = vga_blank_n_r;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout_controller.sv
// Randomized self-checking bench for vga_scanout_controller using a reduced raster and a
// position-arithmetic reference model plus a latency-1 framebuffer model.
module tb_vga_scanout_controller;

  localparam int HA = 40, HF = 6, HS = 8, HB = 10;
  localparam int VA = 20, VF = 3, VS = 2, VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PIPE = 3;

  logic       clock_video = 1'b0;
  logic       reset;
  logic [7:0] pixel_frame0;
  logic [7:0] pixel_frame1;
  logic       frame_select;
  logic       test_pattern;
  logic [9:0] pixel_x_pos;
  logic [9:0] pixel_y_pos;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank_n;
  logic       vga_sync_n;
  logic       vblank;

  always #5 clock_video = ~clock_video;

  vga_scanout_controller #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FB_LATENCY(1)
  ) dut (
    .clock_video  (clock_video),
    .reset        (reset),
    .pixel_frame0 (pixel_frame0),
    .pixel_frame1 (pixel_frame1),
    .frame_select (frame_select),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .pixel_x_pos  (pixel_x_pos),
    .pixel_y_pos  (pixel_y_pos),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vga_blank_n  (vga_blank_n),
    .vga_sync_n   (vga_sync_n),
    .vblank       (vblank)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   t;
  int   mode;
  int   seed0, seed1;
  int   frame_sel [16];
  logic fs_now;
  int   prev_x, prev_y;
  logic stats_on;
  int   hs_low_cnt, vs_low_cnt, hs_falls, first_fall;
  logic prev_hs;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Framebuffer contents as a function of buffer and coordinate
  function automatic logic [7:0] fb_pixel(input int b, input int x, input int y);
    int v;
    if (mode == 0) v = (b != 0) ? 'h03 : 'hE0;
    else if (b != 0) v = x * 11 + y * 7 + seed1;
    else v = x * 3 + y * 5 + seed0;
    return 8'(v);
  endfunction

  // RGB332 to 24-bit by arithmetic replication
  function automatic logic [23:0] ref_colour(input logic [7:0] p);
    int rr, gg, bb;
    rr = int'(p) / 32;
    gg = (int'(p) / 4) % 8;
    bb = int'(p) % 4;
    return {8'(rr * 36 + rr / 2), 8'(gg * 36 + gg / 2), 8'(bb * 85)};
  endfunction

  task automatic check_all();
    int p, h, v, q, hq, vq, k;
    logic act, aq, hs_low, vs_low;
    logic [9:0] ex, ey;
    logic [23:0] rgb;
    logic [7:0] pix;
    ex = 10'd0; ey = 10'd0; act = 1'b0; v = 0;
    if (t >= 1) begin
      p = (t - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      act = (h < HA) && (v < VA);
      if (act) begin
        ex = 10'(h);
        ey = 10'(v);
      end
    end
    check_value("coord", {12'd0, pixel_x_pos, pixel_y_pos}, {12'd0, ex, ey});
    check_value("vblank", {31'd0, vblank}, {31'd0, (t >= 1) && (v >= VA)});
    aq = 1'b0; hs_low = 1'b0; vs_low = 1'b0; rgb = 24'd0;
    if (t >= PIPE) begin
      q  = t - PIPE;
      hq = (q % FRAME) % HT;
      vq = (q % FRAME) / HT;
      k  = q / FRAME;
      aq = (hq < HA) && (vq < VA);
      hs_low = (hq >= HA + HF) && (hq < HA + HF + HS);
      vs_low = (vq >= VA + VF) && (vq < VA + VF + VS);
      pix = fb_pixel(frame_sel[k], hq, vq);
      if (aq) rgb = ref_colour(pix);
    end
    check_value("sync", {28'd0, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n},
                {28'd0, ~hs_low, ~vs_low, aq, 1'b0});
    check_value("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, rgb});
    if (stats_on && t >= PIPE && (t - PIPE) < FRAME) begin
      if (!vga_hsync) hs_low_cnt++;
      if (!vga_vsync) vs_low_cnt++;
      if (prev_hs && !vga_hsync) begin
        hs_falls++;
        if (first_fall < 0) first_fall = t;
      end
      prev_hs = vga_hsync;
      if ((t - PIPE) == FRAME - 1) begin
        check_value("hs_low_cycles", 32'(hs_low_cnt), 32'(HS * VT));
        check_value("vs_low_cycles", 32'(vs_low_cnt), 32'(VS * HT));
        check_value("hs_pulses", 32'(hs_falls), 32'(VT));
        check_value("first_hs_fall", 32'(first_fall), 32'(HA + HF + PIPE));
      end
    end
  endtask

  task automatic step();
    @(posedge clock_video);
    #1;
    t++;
    if ((t % FRAME) == 0 && (t / FRAME) < 16) frame_sel[t / FRAME] = int'(fs_now);
    check_all();
    pixel_frame0 = fb_pixel(0, prev_x, prev_y);
    pixel_frame1 = fb_pixel(1, prev_x, prev_y);
    prev_x = int'(pixel_x_pos);
    prev_y = int'(pixel_y_pos);
    @(negedge clock_video);
  endtask

  task automatic restart_model();
    t = 0;
    prev_x = 0;
    prev_y = 0;
    for (int i = 0; i < 16; i++) frame_sel[i] = 0;
  endtask

  initial begin
    reset = 1'b0;
    frame_select = 1'b0;
    fs_now = 1'b0;
    test_pattern = 1'b0;
    pixel_frame0 = 8'h00;
    pixel_frame1 = 8'h00;
    mode = 0;
    seed0 = 0;
    seed1 = 0;
    stats_on = 1'b1;
    hs_low_cnt = 0; vs_low_cnt = 0; hs_falls = 0; first_fall = -1; prev_hs = 1'b1;
    restart_model();
    repeat (3) @(posedge clock_video);
    #1;
    check_all();
    @(negedge clock_video);
    reset = 1'b1;

    // Constant buffers, toggle mid-frame 1, stop at h=30,v=10 of frame 2
    while (t < 2 * FRAME + 10 * HT + 30) begin
      step();
      if (t == FRAME + (VA / 2) * HT) fs_now = 1'b1;
      if (t == 2 * FRAME + 5 * HT) fs_now = 1'b0;
      frame_select = fs_now;
    end

    reset = 1'b0;
    #1;
    check_value("rst_sync", {30'd0, vga_hsync, vga_vsync}, 32'd3);
    check_value("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    check_value("rst_blank", {31'd0, vga_blank_n}, 32'd0);
    check_value("rst_coord", {12'd0, pixel_x_pos, pixel_y_pos}, 32'd0);
    check_value("rst_vblank", {31'd0, vblank}, 32'd0);
    repeat (3) @(posedge clock_video);
    #1;
    check_value("rst_hold", {11'd0, pixel_x_pos, pixel_y_pos, vga_hsync}, 32'd1);
    @(negedge clock_video);
    restart_model();
    stats_on = 1'b0;
    mode = 1;
    seed0 = int'($urandom_range(0, 255));
    seed1 = int'($urandom_range(0, 255));
    fs_now = 1'(($urandom) & 1);
    frame_select = fs_now;
    reset = 1'b1;

    // Random pixels with random buffer requests
    repeat (4 * FRAME + 10) begin
      step();
      if ($urandom_range(0, 299) == 0) fs_now = ~fs_now;
      frame_select = fs_now;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
